// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor: one full-subtract cell (two half-subtract stages plus a
// borrow flop), LSB first, WIDTH cycles per operation. Define SERIAL_SUB_SAT_EN to clamp d to 0 on final borrow.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: start is sampled only while idle; done is a one-cycle pulse
  // during which d/bo already hold the new result; busy covers the shift phase.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bo_q, bo_d;

  logic             hs1_diff, hs1_borrow;
  logic             hs2_diff, hs2_borrow;
  logic             br_next;
  logic [WIDTH-1:0] res_full;

  // Full-subtract cell built from two half-subtract stages.
  always_comb begin
    hs1_diff   = a_sh_q[0] ^ b_sh_q[0];
    hs1_borrow = ~a_sh_q[0] & b_sh_q[0];
    hs2_diff   = hs1_diff ^ br_q;
    hs2_borrow = ~hs1_diff & br_q;
    br_next    = hs1_borrow | hs2_borrow;
    res_full   = {hs2_diff, r_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_d     = r_q;
    d_d     = d_q;
    bo_d    = bo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          a_sh_d  = a;
          b_sh_d  = b;
          cnt_d   = '0;
          br_d    = 1'b0;
          r_d     = '0;
        end
      end
      SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        r_d    = res_full;
        br_d   = br_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          bo_d    = br_next;
`ifdef SERIAL_SUB_SAT_EN
          d_d     = br_next ? '0 : res_full;
`else
          d_d     = res_full;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_q     <= '0;
      d_q     <= '0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_q     <= r_d;
      d_q     <= d_d;
      bo_q    <= bo_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign d    = d_q;
  assign bo   = bo_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl (WIDTH=8): reset, latency, wrap/saturate,
// back-to-back throughput, ignored start, and mid-operation reset abort.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bo;

  int errors;
  int checks;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bo    (bo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: waits for idle, issues a one-cycle start, returns cycles from accept edge to done (0 = timeout).
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, output int lat);
    for (int i = 0; i < 40 && (busy || done); i++) begin
      @(posedge clk);
      #1;
    end
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_d: got %h expected 00", d); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL reset_bo: got %b expected 0", bo); end
    #2 rst = 1'b0;
  endtask

  task automatic test_basic();
    a = 8'h05;
    b = 8'h03;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_T: got %b expected 1", busy); end
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL basic_shift_T+%0d: got busy=%b done=%b expected busy=1 done=0", k, busy, done);
      end
    end
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_done_T+8: got done=%b busy=%b expected done=1 busy=0", done, busy); end
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL basic_d: got %h expected 02", d); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL basic_bo: got %b expected 0", bo); end
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_wrap();
    int lat;
    logic [W-1:0] exp_d;
`ifdef SERIAL_SUB_SAT_EN
    exp_d = 8'h00;
`else
    exp_d = 8'hFE;
`endif
    do_op(8'h03, 8'h05, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL wrap_latency: got %0d expected 8", lat); end
    checks++; if (d !== exp_d) begin errors++; $display("FAIL wrap_d: got %h expected %h", d, exp_d); end
    checks++; if (bo !== 1'b1) begin errors++; $display("FAIL wrap_bo: got %b expected 1", bo); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int gap;
    for (int i = 0; i < 40 && (busy || done); i++) begin
      @(posedge clk);
      #1;
    end
    a = 8'h00;
    b = 8'h00;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 8'hFF;
    b = 8'hFF;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin lat = n; break; end
    end
    checks++; if (lat !== 8) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 8", lat); end
    checks++; if (d !== 8'h00 || bo !== 1'b0) begin errors++; $display("FAIL b2b_first_result: got d=%h bo=%b expected d=00 bo=0", d, bo); end
    gap = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin gap = n; break; end
    end
    start = 1'b0;
    checks++; if (gap !== 10) begin errors++; $display("FAIL b2b_done_spacing: got %0d expected 10", gap); end
    checks++; if (d !== 8'h00 || bo !== 1'b0) begin errors++; $display("FAIL b2b_second_result: got d=%h bo=%b expected d=00 bo=0", d, bo); end
  endtask

  task automatic test_ignore_start();
    int lat;
    int pulses;
    for (int i = 0; i < 40 && (busy || done); i++) begin
      @(posedge clk);
      #1;
    end
    a = 8'h80;
    b = 8'h01;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    a = 8'h00;
    b = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy: got %b expected 1", busy); end
    lat = 0;
    for (int n = 5; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin lat = n; break; end
    end
    checks++; if (lat !== 8) begin errors++; $display("FAIL ignore_latency: got %0d expected 8", lat); end
    checks++; if (d !== 8'h7F || bo !== 1'b0) begin errors++; $display("FAIL ignore_result: got d=%h bo=%b expected d=7f bo=0", d, bo); end
    pulses = 0;
    for (int n = 0; n < 14; n++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL ignore_extra_done: got %0d pulses expected 0", pulses); end
    checks++; if (d !== 8'h7F) begin errors++; $display("FAIL ignore_d_held: got %h expected 7f", d); end
  endtask

  task automatic test_reset_abort();
    int lat;
    int pulses;
    for (int i = 0; i < 40 && (busy || done); i++) begin
      @(posedge clk);
      #1;
    end
    a = 8'h10;
    b = 8'h20;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #4;
    checks++; if (busy !== 1'b1 || d !== 8'h7F) begin errors++; $display("FAIL abort_pre: got busy=%b d=%h expected busy=1 d=7f", busy, d); end
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_ctrl: got busy=%b done=%b expected 0 0", busy, done); end
    checks++; if (d !== 8'h00 || bo !== 1'b0) begin errors++; $display("FAIL abort_outputs: got d=%h bo=%b expected d=00 bo=0", d, bo); end
    #2 rst = 1'b0;
    pulses = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    checks++; if (pulses !== 0 || busy !== 1'b0) begin errors++; $display("FAIL abort_no_done: got pulses=%0d busy=%b expected 0 0", pulses, busy); end
    do_op(8'h10, 8'h01, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL post_abort_latency: got %0d expected 8", lat); end
    checks++; if (d !== 8'h0F || bo !== 1'b0) begin errors++; $display("FAIL post_abort_result: got d=%h bo=%b expected d=0f bo=0", d, bo); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
